bus_arbiter_2: RTL and testbench
================================

// Module: bus_arbiter_2
// PURPOSE
//  Two-master round-robin bus arbiter; drives Sel/Enable of the downstream 2-input bus multiplexer.
//  Masters 0/1 (e.g. core LSU, debug/DMA port) request the shared MCU data bus.
//  Issues registered one-hot grants and holds ownership until the owner signals Done or drops Req.
//  Downstream mux outputs 0 whenever Enable=0, so the bus reads as all-zero while idle.
// PARAMETERS
//  MaxHold   16  max consecutive cycles one master may own the bus (used only with ARB_TIMEOUT_EN)
//  CntBits    5  hold-counter width; MaxHold <= 2**CntBits-1 is required
// PORTS
//  Clock    in   1  single system clock, rising edge
//  Reset    in   1  asynchronous, active-high reset
//  Req_0    in   1  master 0 bus request, level, held until granted
//  Req_1    in   1  master 1 bus request, level, held until granted
//  Done     in   1  owner's last bus cycle this clock; releases bus at next edge
//  Grant_0  out  1  master 0 owns bus (registered)
//  Grant_1  out  1  master 1 owns bus (registered)
//  Sel      out  1  mux select: 0 = master 0, 1 = master 1 (registered)
//  Enable   out  1  mux enable = Grant_0 | Grant_1
// BEHAVIOUR
//  Reset: state IDLE, Grant_0=Grant_1=0, Enable=0, Sel=0, last_owner=1 (master 0 wins first tie), hold cnt=0.
//  States: IDLE, OWN0, OWN1. Grants one-hot, never both high. All outputs from flops, no comb path from Req.
//  IDLE: Req_0 only -> OWN0; Req_1 only -> OWN1; both -> master != last_owner; none -> IDLE.
//  Latency: Req seen at edge N -> Grant/Enable/Sel valid after edge N (first bus cycle N+1).
//  OWNx: Done=1 or Req_x=0 -> IDLE at next edge; last_owner<=x. Done with Req_x=0 is the same release.
//  Release always passes through IDLE for exactly >=1 cycle (one dead bus cycle, Enable=0); no direct OWN0->OWN1.
//  Sel holds last owner in IDLE (no glitching of the mux select); only updates on entry to OWNx.
//  Done while IDLE: ignored. Req of non-owner while owning: waits, no effect on current owner.
//  Same master re-requests after release with other master idle: regranted after one IDLE cycle.
//  Reset mid-ownership: outputs drop to reset values immediately (async), grant lost, no completion.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: hold cnt clears on entry to OWNx, increments each owned cycle;
//   when cnt == MaxHold-1 and no Done, force release -> IDLE, last_owner<=x (other master gets priority).
//   Counter saturates, never wraps; cnt reset to 0 in IDLE.
//  ARB_TIMEOUT_EN undefined: no counter logic; owner holds bus indefinitely until Done or Req drop.
//   MaxHold/CntBits present but unused.
// STRUCTURE
//  Shared package mcu_arb_pkg: state encodings ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2; master IDs.
//  Sub-module arb_hold_timer (counter + expiry flag), instantiated only under ARB_TIMEOUT_EN.
//  Top: next-state/priority logic + output flops.
// TESTING
//  Reset, then Req_0=1 only -> after one edge Grant_0=1, Sel=0, Enable=1; Done pulse -> next edge Enable=0.
//  Req_0=Req_1=1 from IDLE after reset -> Grant_0 first; on Done -> 1 IDLE cycle, then Grant_1, Sel=1.
//  Continuous Req_0=Req_1=1, Done every 3rd owned cycle -> strict alternation 0,1,0,1 with 1-cycle gaps.
//  Assert Reset while OWN1 -> Grant_1/Enable fall asynchronously, Sel=0; post-reset Req_1 regranted in 1 cycle.
//  ARB_TIMEOUT_EN, MaxHold=4, Req_0 held, no Done, Req_1=1 -> Grant_0 exactly 4 cycles, IDLE 1, then Grant_1.
//  ARB_TIMEOUT_EN undefined, same stimulus over 100 cycles -> Grant_0 never drops; check grants one-hot always.

Source files
------------

// File: rtl/mcu_arb_pkg.sv
// Shared definitions for the MCU data-bus arbiter: FSM state encodings and master IDs.
package mcu_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    MASTER_0 = 1'b0,
    MASTER_1 = 1'b1
  } master_id_e;

  // Ownership state that corresponds to a given master.
  function automatic arb_state_e own_state(input master_id_e id);
    return (id == MASTER_0) ? ARB_OWN0 : ARB_OWN1;
  endfunction

endpackage : mcu_arb_pkg

// File: rtl/arb_hold_timer.sv
// Saturating hold counter for the bus arbiter; flags when the current owner has used its
// last permitted cycle. Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_hold_timer #(
  parameter int MaxHold = 16,
  parameter int CntBits = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  output logic expired
);

  logic [CntBits-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop
  // samples values from before the edge regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!active) begin
      cnt_q <= '0;
    end else if (cnt_q != {CntBits{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The cycle in which cnt reaches MaxHold-1 is the owner's final granted cycle.
  assign expired = active && (cnt_q == CntBits'(MaxHold - 1));

endmodule : arb_hold_timer

// File: rtl/bus_arbiter_2.sv
// Two-master round-robin arbiter driving Sel/Enable of the shared bus mux.
// Optional ownership timeout is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_2
  import mcu_arb_pkg::*;
#(
  parameter int MaxHold = 16,
  parameter int CntBits = 5
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Req_0,
  input  logic Req_1,
  input  logic Done,
  output logic Grant_0,
  output logic Grant_1,
  output logic Sel,
  output logic Enable
);

  arb_state_e state_q, state_d;
  master_id_e last_owner_q, last_owner_d;
  logic       sel_q, sel_d;
  logic       hold_expired;

  if (MaxHold < 1 || MaxHold > (2 ** CntBits) - 1) begin : g_bad_cfg
    $error("bus_arbiter_2: MaxHold must be in 1 .. 2**CntBits-1");
  end

`ifdef ARB_TIMEOUT_EN
  arb_hold_timer #(
    .MaxHold (MaxHold),
    .CntBits (CntBits)
  ) u_hold_timer (
    .clk     (Clock),
    .rst     (Reset),
    .active  (state_q != ARB_IDLE),
    .expired (hold_expired)
  );
`else
  assign hold_expired = 1'b0;
`endif

  // NOTE: every variable written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    sel_d        = sel_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (Req_0 && Req_1) begin
          // Tie goes to whichever master did not own the bus most recently.
          state_d = (last_owner_q == MASTER_0) ? own_state(MASTER_1) : own_state(MASTER_0);
        end else if (Req_0) begin
          state_d = ARB_OWN0;
        end else if (Req_1) begin
          state_d = ARB_OWN1;
        end
        if (state_d == ARB_OWN0) sel_d = 1'b0;
        if (state_d == ARB_OWN1) sel_d = 1'b1;
      end
      ARB_OWN0: begin
        if (Done || !Req_0 || hold_expired) begin
          state_d      = ARB_IDLE;
          last_owner_d = MASTER_0;
        end
      end
      ARB_OWN1: begin
        if (Done || !Req_1 || hold_expired) begin
          state_d      = ARB_IDLE;
          last_owner_d = MASTER_1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= MASTER_1;
      sel_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
    end
  end

  // Outputs decode flop state only; Req never reaches them combinationally.
  assign Grant_0 = (state_q == ARB_OWN0);
  assign Grant_1 = (state_q == ARB_OWN1);
  assign Sel     = sel_q;
  assign Enable  = Grant_0 | Grant_1;

endmodule : bus_arbiter_2

// File: tb/tb_bus_arbiter_2.sv
// Directed self-checking bench for bus_arbiter_2 (MaxHold=4); the timeout scenario
// follows whether ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter_2;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Req_0 = 1'b0;
  logic Req_1 = 1'b0;
  logic Done  = 1'b0;
  logic Grant_0, Grant_1, Sel, Enable;

  int checks = 0;
  int errors = 0;

  bus_arbiter_2 #(
    .MaxHold (4),
    .CntBits (5)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Req_0   (Req_0),
    .Req_1   (Req_1),
    .Done    (Done),
    .Grant_0 (Grant_0),
    .Grant_1 (Grant_1),
    .Sel     (Sel),
    .Enable  (Enable)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic g0, input logic g1,
                            input logic sel, input logic en);
    check({tag, ".grant_0"}, Grant_0, g0);
    check({tag, ".grant_1"}, Grant_1, g1);
    check({tag, ".sel"}, Sel, sel);
    check({tag, ".enable"}, Enable, en);
    check({tag, ".one_hot"}, Grant_0 & Grant_1, 1'b0);
  endtask

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    Reset = 1'b0;

    // Single request, then Done releases on the next edge
    Req_0 = 1'b1;
    step();
    check_outs("req0_grant", 1'b1, 1'b0, 1'b0, 1'b1);
    Done = 1'b1;
    step();
    check_outs("req0_done", 1'b0, 1'b0, 1'b0, 1'b0);
    Done  = 1'b0;
    Req_0 = 1'b0;
    step();
    check_outs("idle_hold", 1'b0, 1'b0, 1'b0, 1'b0);

    // Tie after reset: master 0 first, one dead cycle, then master 1
    pulse_reset();
    Req_0 = 1'b1;
    Req_1 = 1'b1;
    step();
    check_outs("tie_first", 1'b1, 1'b0, 1'b0, 1'b1);
    Done = 1'b1;
    step();
    check_outs("tie_gap", 1'b0, 1'b0, 1'b0, 1'b0);
    Done = 1'b0;
    step();
    check_outs("tie_second", 1'b0, 1'b1, 1'b1, 1'b1);
    Done = 1'b1;
    step();
    check_outs("sel_held_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    Done = 1'b0;

    // Continuous requests, Done on every 3rd owned cycle: 0,1,0,1 with 1-cycle gaps
    for (int g = 0; g < 4; g++) begin
      logic own1;
      own1 = logic'(g % 2);
      for (int c = 1; c <= 3; c++) begin
        step();
        check_outs($sformatf("alt%0d_c%0d", g, c), ~own1, own1, own1, 1'b1);
      end
      Done = 1'b1;
      step();
      check_outs($sformatf("alt%0d_gap", g), 1'b0, 1'b0, own1, 1'b0);
      Done = 1'b0;
    end
    Req_0 = 1'b0;
    Req_1 = 1'b0;
    step();
    check_outs("alt_end", 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset while master 1 owns the bus: outputs drop without a clock edge
    Req_1 = 1'b1;
    step();
    check_outs("own1", 1'b0, 1'b1, 1'b1, 1'b1);
    #2 Reset = 1'b1;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #1 Reset = 1'b0;
    step();
    check_outs("post_reset_regrant", 1'b0, 1'b1, 1'b1, 1'b1);
    Req_1 = 1'b0;
    step();
    check_outs("req1_drop", 1'b0, 1'b0, 1'b1, 1'b0);

    // Done while idle is ignored; non-owner request waits
    Done = 1'b1;
    step();
    check_outs("done_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    Done  = 1'b0;
    Req_0 = 1'b1;
    step();
    check_outs("own0", 1'b1, 1'b0, 1'b0, 1'b1);
    Req_1 = 1'b1;
    step();
    check_outs("req1_waits", 1'b1, 1'b0, 1'b0, 1'b1);
    Req_0 = 1'b0;
    step();
    check_outs("req0_drop", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("waiter_granted", 1'b0, 1'b1, 1'b1, 1'b1);
    Req_0 = 1'b0;
    Req_1 = 1'b0;
    step();

    // Hold behaviour: Req_0 held, Req_1 pending, no Done
    pulse_reset();
    Req_0 = 1'b1;
    Req_1 = 1'b1;
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      step();
      check_outs($sformatf("timeout_own0_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1);
    end
    step();
    check_outs("timeout_gap", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("timeout_own1", 1'b0, 1'b1, 1'b1, 1'b1);
`else
    for (int c = 1; c <= 100; c++) begin
      step();
      check_outs($sformatf("hold_own0_c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bus_arbiter_2
